// File: rtl/ysyx_22050854_divider_pkg.sv
// Shared definitions for the iterative radix-2 divider: FSM encoding and
// iteration counts for full-width and word operations.
package ysyx_22050854_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_STEPS_D = 64;
  localparam int DIV_STEPS_W = 32;
  localparam int DIV_CNT_W   = 7;

endpackage

// File: rtl/ysyx_22050854_divider_if.sv
// Request/response bundle between the execute stage (master) and the divider
// (slave).
interface ysyx_22050854_divider_if #(
  parameter int XLEN = 64
);
  logic            div_valid;
  logic            div_ready;
  logic            div_signed;
  logic            divw;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output div_valid, div_signed, divw, dividend, divisor, flush, out_ready,
    input  div_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  div_valid, div_signed, divw, dividend, divisor, flush, out_ready,
    output div_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/ysyx_22050854_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes: shifts the next
// dividend bit into the partial remainder and retires one quotient bit.
module ysyx_22050854_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);
  logic [XLEN:0] sh;
  logic [XLEN:0] diff;

  // rem < dvs always holds, so sh fits XLEN+1 bits and diff[XLEN] is the borrow
  always_comb begin
    sh   = {rem, quo[XLEN-1]};
    diff = sh - {1'b0, dvs};
    if (diff[XLEN]) begin
      rem_nxt = sh[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/ysyx_22050854_divider.sv
// Multi-cycle integer divider for div/divu/rem/remu and their word forms.
// Operands become magnitudes on acceptance; signs are reapplied on completion.
module ysyx_22050854_divider
  import ysyx_22050854_divider_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_22050854_divider_if.slave    dif
);

  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic sgn);
    return sgn ? {{(XLEN-32){v[31]}}, v[31:0]} : {{(XLEN-32){1'b0}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v,
                                                 input logic neg, input logic w);
    logic [XLEN-1:0] r;
    r = neg ? -v : v;
    return w ? word_ext(r, 1'b1) : r;
  endfunction

  div_state_e state, nxt;

  logic [DIV_CNT_W-1:0] cnt;
  logic [XLEN-1:0]      rem_r, quo_r, dvs_r;
  logic                 neg_q, neg_r, word_r;
  logic [XLEN-1:0]      quotient_r, remainder_r;

  logic [XLEN-1:0] op_a, op_b, mag_a, mag_b, min_neg;
  logic [XLEN-1:0] rem_nxt, quo_nxt;
  logic            sa, sb, div_zero, ovf, accept, last;

  always_comb begin
    op_a     = dif.divw ? word_ext(dif.dividend, dif.div_signed) : dif.dividend;
    op_b     = dif.divw ? word_ext(dif.divisor, dif.div_signed) : dif.divisor;
    sa       = dif.div_signed & op_a[XLEN-1];
    sb       = dif.div_signed & op_b[XLEN-1];
    mag_a    = sa ? -op_a : op_a;
    mag_b    = sb ? -op_b : op_b;
    min_neg  = dif.divw ? {{(XLEN-32){1'b1}}, 1'b1, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (op_b == '0);
    ovf      = dif.div_signed && (op_a == min_neg) && (op_b == '1);
    accept   = (state == IDLE) && dif.div_valid && !dif.flush;
    last     = (cnt == DIV_CNT_W'(1));
  end

  ysyx_22050854_div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_r),
    .quo     (quo_r),
    .dvs     (dvs_r),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // flush overrides every other transition, including a same-cycle request
  always_comb begin
    nxt           = state;
    dif.div_ready = (state == IDLE);
    dif.out_valid = (state == DONE);
    case (state)
      IDLE:    if (dif.div_valid) nxt = (div_zero || ovf) ? DONE : BUSY;
      BUSY:    if (last) nxt = DONE;
      DONE:    if (dif.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (dif.flush) nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_r       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      word_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else if (accept) begin
      word_r <= dif.divw;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      dvs_r  <= mag_b;
      rem_r  <= '0;
      // word magnitudes sit in the upper half so 32 steps consume them fully
      quo_r  <= dif.divw ? (mag_a << 32) : mag_a;
      cnt    <= dif.divw ? DIV_CNT_W'(DIV_STEPS_W) : DIV_CNT_W'(DIV_STEPS_D);
      if (div_zero) begin
        quotient_r  <= '1;
        remainder_r <= dif.divw ? word_ext(op_a, 1'b1) : op_a;
      end else if (ovf) begin
        quotient_r  <= op_a;
        remainder_r <= '0;
      end
    end else if (state == BUSY && !dif.flush) begin
      rem_r <= rem_nxt;
      quo_r <= quo_nxt;
      cnt   <= cnt - DIV_CNT_W'(1);
      if (last) begin
        quotient_r  <= apply_sign(quo_nxt, neg_q, word_r);
        remainder_r <= apply_sign(rem_nxt, neg_r, word_r);
      end
    end
  end

  assign dif.quotient  = quotient_r;
  assign dif.remainder = remainder_r;

endmodule

// File: tb/tb_ysyx_22050854_divider.sv
// Directed bench for the iterative divider: latency, sign handling, bypass
// cases, word results, flush, result hold and mid-operation reset.
module tb_ysyx_22050854_divider;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  ysyx_22050854_divider_if #(.XLEN(64)) dif ();

  ysyx_22050854_divider #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic run(input string tag, input logic sgn, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] eq, input logic [63:0] er, input int elat);
    int lat;
    @(negedge clk);
    dif.div_valid  = 1'b1;
    dif.div_signed = sgn;
    dif.divw       = w;
    dif.dividend   = a;
    dif.divisor    = b;
    @(negedge clk);
    dif.div_valid = 1'b0;
    lat = 1;
    while (!dif.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_q"}, dif.quotient, eq);
    chk({tag, "_r"}, dif.remainder, er);
    chk({tag, "_rdy_done"}, 64'(dif.div_ready), 64'd0);
    @(negedge clk);
    chk({tag, "_ov_after"}, 64'(dif.out_valid), 64'd0);
    chk({tag, "_rdy_after"}, 64'(dif.div_ready), 64'd1);
  endtask

  initial begin
    int seen;
    n_assert       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    dif.div_valid  = 1'b0;
    dif.div_signed = 1'b0;
    dif.divw       = 1'b0;
    dif.dividend   = '0;
    dif.divisor    = '0;
    dif.flush      = 1'b0;
    dif.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(dif.div_ready), 64'd1);
    chk("rst_ovalid", 64'(dif.out_valid), 64'd0);
    chk("rst_q", dif.quotient, 64'd0);
    chk("rst_r", dif.remainder, 64'd0);
    rst = 1'b0;

    run("u100_7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
    run("s_m7_2", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("s_7_m2", 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
        64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
    run("div0", 1'b0, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
    run("ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 64'd0, 1);
    run("w_min_1", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'd1,
        64'hFFFF_FFFF_8000_0000, 64'd0, 33);
    run("w_m7_2", 1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
        64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run("wu_max_1", 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
        64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33);
    run("w_div0", 1'b0, 1'b1, 64'h0000_0000_8000_0005, 64'h0000_0001_0000_0000,
        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 1);

    // flush in the 10th BUSY cycle
    @(negedge clk);
    dif.div_valid  = 1'b1;
    dif.div_signed = 1'b0;
    dif.divw       = 1'b0;
    dif.dividend   = 64'd1000;
    dif.divisor    = 64'd3;
    @(negedge clk);
    dif.div_valid = 1'b0;
    repeat (9) @(negedge clk);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    chk("flush_idle_rdy", 64'(dif.div_ready), 64'd1);
    chk("flush_ovalid", 64'(dif.out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dif.out_valid) seen++;
    end
    chk("flush_no_result", 64'(seen), 64'd0);

    // result held while the consumer stalls
    dif.out_ready = 1'b0;
    @(negedge clk);
    dif.div_valid = 1'b1;
    dif.dividend  = 64'd9;
    dif.divisor   = 64'd3;
    @(negedge clk);
    dif.div_valid = 1'b0;
    seen = 1;
    while (!dif.out_valid && seen < 200) begin
      @(negedge clk);
      seen++;
    end
    chk("hold_lat", 64'(seen), 64'd65);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ovalid", 64'(dif.out_valid), 64'd1);
      chk("hold_q", dif.quotient, 64'd3);
      chk("hold_r", dif.remainder, 64'd0);
      @(negedge clk);
    end
    dif.out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", 64'(dif.out_valid), 64'd0);

    // reset in the middle of an operation
    @(negedge clk);
    dif.div_valid = 1'b1;
    dif.dividend  = 64'd100;
    dif.divisor   = 64'd7;
    @(negedge clk);
    dif.div_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_q", dif.quotient, 64'd0);
    chk("mid_rst_r", dif.remainder, 64'd0);
    chk("mid_rst_rdy", 64'(dif.div_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dif.out_valid) seen++;
    end
    chk("mid_rst_no_result", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
